// File: rtl/instruction_fetch_unit_pkg.sv
// Shared IF-stage definitions: datapath width, bubble encoding and fetch FSM states.
package instruction_fetch_unit_pkg;

  localparam int unsigned XLen = 32;

  // addi x0,x0,0 -- what the IF/ID register shows whenever it holds a bubble
  localparam logic [XLen-1:0] NopInstr = 32'h0000_0013;

  typedef enum logic [1:0] {
    StFetch = 2'd0,  // request issued at PC every cycle
    StHold  = 2'd1,  // IF/ID stalled, fetched word parked in the skid buffer
    StDrain = 2'd2   // wrong-path request still outstanding, waiting to drop it
  } fetch_state_e;

  // Next sequential fetch address, wrapping at the top of the address space
  function automatic logic [XLen-1:0] seq_next(input logic [XLen-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_skid.sv
// One-entry {instr, pc} holding register used while IF/ID is stalled.
module fetch_skid_buffer
  import instruction_fetch_unit_pkg::*;
(
  input  logic            CLK,
  input  logic            RESET,
  input  logic            load,
  input  logic            clear,
  input  logic [XLen-1:0] load_instr,
  input  logic [XLen-1:0] load_pc,
  output logic [XLen-1:0] instr,
  output logic [XLen-1:0] pc
);

  logic [XLen-1:0] instr_q;
  logic [XLen-1:0] pc_q;

  // Capture on load; clear drops a parked word that became wrong-path
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      instr_q <= '0;
      pc_q    <= '0;
    end else if (clear) begin
      instr_q <= '0;
      pc_q    <= '0;
    end else if (load) begin
      instr_q <= load_instr;
      pc_q    <= load_pc;
    end
  end

  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, issues instruction-memory reads, fills IF/ID and honours EX redirects,
// squashing wrong-path words even when the request that fetches them cannot be aborted.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [XLen-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLen-1:0] NOP_INSTR = NopInstr
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            branch_or_jump_signal,
  input  logic [XLen-1:0] branch_jump_address,
  input  logic            stall,
  output logic            imem_read,
  output logic [XLen-1:0] imem_address,
  input  logic [XLen-1:0] imem_readdata,
  input  logic            imem_busywait,
  output logic [XLen-1:0] instr_out,
  output logic [XLen-1:0] pc_out,
  output logic [XLen-1:0] pc_plus4_out,
  output logic            valid_out
);

  fetch_state_e    state_q, state_d;
  logic [XLen-1:0] pc_q, pc_d;
  logic [XLen-1:0] pending_q, pending_d;
  logic [XLen-1:0] instr_q, instr_d;
  logic [XLen-1:0] pc_out_q, pc_out_d;
  logic [XLen-1:0] pc_plus4_q, pc_plus4_d;
  logic            valid_q, valid_d;

  logic            skid_load;
  logic            skid_clear;
  logic [XLen-1:0] skid_instr;
  logic [XLen-1:0] skid_pc;

  fetch_skid_buffer u_skid (
    .CLK        (CLK),
    .RESET      (RESET),
    .load       (skid_load),
    .clear      (skid_clear),
    .load_instr (imem_readdata),
    .load_pc    (pc_q),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  // Request is a pure function of state; PC doubles as the (stable) fetch address
  assign imem_read    = (state_q != StHold) & ~RESET;
  assign imem_address = pc_q;

  assign instr_out    = instr_q;
  assign pc_out       = pc_out_q;
  assign pc_plus4_out = pc_plus4_q;
  assign valid_out    = valid_q;

  // Next-state, next-PC and IF/ID update; redirect beats stall beats advance
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pending_d  = pending_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    case (state_q)
      StFetch: begin
        if (!imem_busywait) begin
          if (branch_or_jump_signal) begin
            pc_d    = branch_jump_address;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
          end else if (stall) begin
            // Word arrived but IF/ID is frozen: park it and move on
            skid_load = 1'b1;
            pc_d      = seq_next(pc_q);
            state_d   = StHold;
          end else begin
            instr_d    = imem_readdata;
            pc_out_d   = pc_q;
            pc_plus4_d = seq_next(pc_q);
            valid_d    = 1'b1;
            pc_d       = seq_next(pc_q);
          end
        end else begin
          if (branch_or_jump_signal) begin
            // The in-flight request must complete before the target can be issued
            pending_d = branch_jump_address;
            valid_d   = 1'b0;
            instr_d   = NOP_INSTR;
            state_d   = StDrain;
          end else if (!stall) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
          end
        end
      end

      StHold: begin
        if (branch_or_jump_signal) begin
          skid_clear = 1'b1;
          pc_d       = branch_jump_address;
          valid_d    = 1'b0;
          instr_d    = NOP_INSTR;
          state_d    = StFetch;
        end else if (!stall) begin
          instr_d    = skid_instr;
          pc_out_d   = skid_pc;
          pc_plus4_d = seq_next(skid_pc);
          valid_d    = 1'b1;
          state_d    = StFetch;
        end
      end

      StDrain: begin
        if (branch_or_jump_signal) begin
          pending_d = branch_jump_address;
        end
        if (!imem_busywait) begin
          pc_d    = branch_or_jump_signal ? branch_jump_address : pending_q;
          state_d = StFetch;
        end
      end

      default: begin
        state_d = StFetch;
      end
    endcase
  end

  // State and IF/ID registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      pending_q  <= '0;
      instr_q    <= NOP_INSTR;
      pc_out_q   <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pending_q  <= pending_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for the IF stage with a transaction-level reference model and per-cycle compare.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        redir;
  logic [31:0] target;
  logic        stall;
  logic        busy;

  logic        imem_read, imem_read_hi;
  logic [31:0] imem_address, imem_address_hi;
  logic [31:0] rdata, rdata_hi;
  logic [31:0] instr_out, instr_out_hi;
  logic [31:0] pc_out, pc_out_hi;
  logic [31:0] pc_plus4_out, pc_plus4_out_hi;
  logic        valid_out, valid_out_hi;

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  // Memory image: every word is tagged with its own address
  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign rdata    = tag(imem_address);
  assign rdata_hi = tag(imem_address_hi);

  always #5 CLK = ~CLK;

  instruction_fetch_unit dut (
    .CLK                   (CLK),
    .RESET                 (RESET),
    .branch_or_jump_signal (redir),
    .branch_jump_address   (target),
    .stall                 (stall),
    .imem_read             (imem_read),
    .imem_address          (imem_address),
    .imem_readdata         (rdata),
    .imem_busywait         (busy),
    .instr_out             (instr_out),
    .pc_out                (pc_out),
    .pc_plus4_out          (pc_plus4_out),
    .valid_out             (valid_out)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (
    .CLK                   (CLK),
    .RESET                 (RESET),
    .branch_or_jump_signal (redir),
    .branch_jump_address   (target),
    .stall                 (stall),
    .imem_read             (imem_read_hi),
    .imem_address          (imem_address_hi),
    .imem_readdata         (rdata_hi),
    .imem_busywait         (busy),
    .instr_out             (instr_out_hi),
    .pc_out                (pc_out_hi),
    .pc_plus4_out          (pc_plus4_out_hi),
    .valid_out             (valid_out_hi)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: where fetching goes next, what IF/ID shows, what is parked or doomed
  logic [31:0] m_next;       // address being requested
  bit          m_shown;      // IF/ID holds a real instruction
  logic [31:0] m_shown_pc;
  bit          m_parked;     // a fetched word waits for the stall to lift
  logic [31:0] m_parked_pc;
  bit          m_doomed;     // outstanding request is wrong-path
  logic [31:0] m_resume;     // where to go once it retires

  task automatic model_reset();
    m_next = 32'h0; m_shown = 0; m_shown_pc = 0;
    m_parked = 0; m_parked_pc = 0; m_doomed = 0; m_resume = 0;
  endtask

  task automatic model_edge(input bit r, input logic [31:0] t, input bit s, input bit b);
    if (m_doomed) begin
      if (r) m_resume = t;
      if (!b) begin
        m_next   = m_resume;
        m_doomed = 0;
      end
    end else if (m_parked) begin
      if (r) begin
        m_parked = 0; m_shown = 0; m_next = t;
      end else if (!s) begin
        m_parked = 0; m_shown = 1; m_shown_pc = m_parked_pc;
      end
    end else if (r) begin
      m_shown = 0;
      if (b) begin m_doomed = 1; m_resume = t; end
      else m_next = t;
    end else if (!b) begin
      if (s) begin m_parked = 1; m_parked_pc = m_next; end
      else begin m_shown = 1; m_shown_pc = m_next; end
      m_next = m_next + 32'd4;
    end else if (!s) begin
      m_shown = 0;
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, return just after it
  task automatic step(input bit r, input logic [31:0] t, input bit s, input bit b);
    redir = r; target = t; stall = s; busy = b;
    @(posedge CLK);
    model_edge(r, t, s, b);
    #1;
  endtask

  // Per-cycle compare, away from the active edge
  always @(negedge CLK) begin
    if (checking && !RESET) begin
      chk("imem_read", {31'd0, imem_read}, {31'd0, !m_parked});
      chk("imem_address", imem_address, m_next);
      chk("valid_out", {31'd0, valid_out}, {31'd0, m_shown});
      if (m_shown) begin
        chk("pc_out", pc_out, m_shown_pc);
        chk("pc_plus4_out", pc_plus4_out, m_shown_pc + 32'd4);
        chk("instr_out", instr_out, tag(m_shown_pc));
      end else begin
        chk("instr_out_nop", instr_out, NOP);
      end
    end
  end

  initial begin
    RESET = 1'b1; redir = 0; target = 0; stall = 0; busy = 0;
    model_reset();
    #12;
    chk("rst_read", {31'd0, imem_read}, 32'd0);
    chk("rst_addr", imem_address, 32'h0);
    chk("rst_instr", instr_out, NOP);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_pc4", pc_plus4_out, 32'h0);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    RESET = 1'b0;
    checking = 1'b1;

    // 1: sequential hits
    step(0, 0, 0, 0); chk("t1_pc0", pc_out, 32'h0);
    step(0, 0, 0, 0); chk("t1_pc4", pc_out, 32'h4);
    step(0, 0, 0, 0); chk("t1_pc8", pc_out, 32'h8);
    chk("t1_instr8", instr_out, 32'hC0DE_0008);

    // 2: redirect at a hit, 0xC must never show
    step(1, 32'h100, 0, 0);
    chk("t2_addr", imem_address, 32'h100);
    chk("t2_bubble", {31'd0, valid_out}, 32'd0);
    step(0, 0, 0, 0); chk("t2_pc", pc_out, 32'h100);
    step(0, 0, 0, 0);

    // 3a: redirect to 0x200 during a 3-cycle miss on 0x40
    step(1, 32'h40, 0, 0);
    step(0, 0, 0, 1);
    step(1, 32'h200, 0, 1);
    chk("t3_hold_addr", imem_address, 32'h40);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("t3_addr200", imem_address, 32'h200);
    chk("t3_valid0", {31'd0, valid_out}, 32'd0);
    step(0, 0, 0, 0); chk("t3_pc200", pc_out, 32'h200);
    // 3b: second redirect while draining wins
    step(1, 32'h40, 0, 0);
    step(1, 32'h200, 0, 1);
    step(1, 32'h300, 0, 1);
    step(0, 0, 0, 0);
    chk("t3_addr300", imem_address, 32'h300);
    step(0, 0, 0, 0); chk("t3_pc300", pc_out, 32'h300);

    // 4: stall three cycles on a hit at 0x20
    step(1, 32'h1C, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("t4_read0", {31'd0, imem_read}, 32'd0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    chk("t4_frozen", pc_out, 32'h1C);
    step(0, 0, 0, 0); chk("t4_pc20", pc_out, 32'h20);
    step(0, 0, 0, 0); chk("t4_pc24", pc_out, 32'h24);
    // stall during a miss keeps outputs
    step(0, 0, 1, 1); chk("t4_missstall", pc_out, 32'h24);
    step(0, 0, 0, 0);

    // 5: redirect and stall on the same edge while holding
    step(0, 0, 1, 0);
    step(1, 32'h500, 1, 0);
    chk("t5_addr", imem_address, 32'h500);
    chk("t5_valid0", {31'd0, valid_out}, 32'd0);
    step(0, 0, 0, 0); chk("t5_pc", pc_out, 32'h500);

    // 6a: async reset in the middle of a miss
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    #2;
    RESET = 1'b1;
    #1;
    chk("t6_read0", {31'd0, imem_read}, 32'd0);
    chk("t6_addr", imem_address, 32'h0);
    chk("t6_valid", {31'd0, valid_out}, 32'd0);
    chk("t6_instr", instr_out, NOP);
    chk("t6_pc", pc_out, 32'h0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    model_reset();
    // 6b: reset PC at the top of the address space wraps to 0
    chk("t6_hi_addr", imem_address_hi, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    chk("t6_hi_pc", pc_out_hi, 32'hFFFF_FFFC);
    chk("t6_hi_pc4", pc_plus4_out_hi, 32'h0);
    chk("t6_hi_valid", {31'd0, valid_out_hi}, 32'd1);
    chk("t6_hi_next", imem_address_hi, 32'h0);
    step(0, 0, 0, 0);
    chk("t6_hi_pc0", pc_out_hi, 32'h0);

    @(negedge CLK);
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
